gray_sync_decoder: RTL and testbench

Receiving stage placed directly downstream of the binary-to-Gray encoder. It synchronises a Gray-coded word into the local clock domain and filters out short glitches. Accepted codes are converted back to binary. On every accepted change it reports the modular step size and flags any change that is not a single-bit Gray step.

---
 rtl/gray_sync_decoder_if.sv | 23 ++
 rtl/gray_sync_decoder.sv | 139 +++++++++++++
 tb/tb_gray_sync_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gray_sync_decoder_if.sv
// Bundle of the Gray-code input word and the decoded result/status outputs.
// The master drives gray_in and observes results. The slave is the decoder.
interface gray_sync_decoder_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     gray_in;
  logic [WIDTH-1:0]     bin_out;
  logic                 bin_valid;
  logic [WIDTH-1:0]     delta;
  logic                 step_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output gray_in,
    input  bin_out, bin_valid, delta, step_err, err_cnt
  );

  modport slave (
    input  gray_in,
    output bin_out, bin_valid, delta, step_err, err_cnt
  );
endinterface

// File: rtl/gray_sync_decoder.sv
// Gray-code receiver. It synchronises a possibly asynchronous Gray word and
// accepts a new code only after it has been stable for several samples. It
// converts the accepted code to binary, reports the modular step, and counts
// non-single-bit transitions.
module gray_sync_decoder #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int ERR_CNT_W     = 8
) (
  input logic                clk,
  input logic                rst,
  gray_sync_decoder_if.slave bus
);

  localparam int                 CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [0:0]         TRACK    = 1'b0;
  localparam logic [0:0]         SETTLE   = 1'b1;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when exactly one bit is set, i.e. a legal single Gray step.
  function automatic logic is_single_bit(input logic [WIDTH-1:0] x);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n += int'(x[i]);
    end
    return (n == 1);
  endfunction

  logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
  logic [0:0]           r_state;
  logic [WIDTH-1:0]     r_acc_gray;
  logic [WIDTH-1:0]     r_cand;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_bin;
  logic [WIDTH-1:0]     r_delta;
  logic                 r_valid;
  logic                 r_step_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0]     w_sample;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_new_bin;
  logic                 w_step_err;

  assign w_sample   = r_sync[SYNC_STAGES-1];
  assign w_accept   = (r_state == SETTLE) && (w_sample == r_cand) && (r_cnt == CNT_LAST);
  assign w_new_bin  = gray2bin(r_cand);
  assign w_step_err = !is_single_bit(r_cand ^ r_acc_gray);

  // Multi-flop synchroniser chain bringing gray_in into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Stability filter: track a candidate code and accept it once it has held long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= TRACK;
      r_acc_gray <= '0;
      r_cand     <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        TRACK: begin
          if (w_sample != r_acc_gray) begin
            r_cand  <= w_sample;
            r_cnt   <= CNT_W'(1);
            r_state <= SETTLE;
          end
        end
        default: begin
          if (w_sample == r_cand) begin
            if (r_cnt == CNT_LAST) begin
              r_acc_gray <= r_cand;
              r_state    <= TRACK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_sample == r_acc_gray) begin
            // Sample fell back to the accepted code: the candidate was a glitch.
            r_state <= TRACK;
          end else begin
            r_cand <= w_sample;
            r_cnt  <= CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Result registers update only on accept; bin_valid pulses for that single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin      <= '0;
      r_delta    <= '0;
      r_valid    <= 1'b0;
      r_step_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_bin      <= w_new_bin;
        r_delta    <= w_new_bin - r_bin;
        r_step_err <= w_step_err;
        if (w_step_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.bin_out   = r_bin;
  assign bus.delta     = r_delta;
  assign bus.bin_valid = r_valid;
  assign bus.step_err  = r_step_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder: a vector table of accepted changes plus
// hand-written sequences for glitch rejection, mid-settle reset and counter saturation.
module tb_gray_sync_decoder;

  logic clk;
  logic rst;

  gray_sync_decoder_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();

  gray_sync_decoder #(
    .WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(3), .ERR_CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [3:0] gray;
    logic [3:0] bin;
    logic [3:0] delta;
    logic       se;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for a bin_valid pulse; edges counts the rising edges taken.
  task automatic wait_valid(output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.bin_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic apply_code(input logic [3:0] code, output int edges, output bit seen);
    bus.gray_in = code;
    wait_valid(edges, seen);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.gray_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int  edges;
    bit  seen;
    bit  any_valid;
    int  pulses;
    int  bad;
    int  exp_ec;

    // accepted code, binary, delta, step_err, err_cnt after each accept
    vecs[0] = '{4'b0001, 4'd1,  4'd1,  1'b0, 8'd0};
    vecs[1] = '{4'b0111, 4'd5,  4'd4,  1'b1, 8'd1};
    vecs[2] = '{4'b1000, 4'd15, 4'd10, 1'b1, 8'd2};
    vecs[3] = '{4'b0000, 4'd0,  4'd1,  1'b0, 8'd2};
    vecs[4] = '{4'b1000, 4'd15, 4'd15, 1'b0, 8'd2};
    vecs[5] = '{4'b1001, 4'd14, 4'd15, 1'b0, 8'd2};
    vecs[6] = '{4'b0011, 4'd2,  4'd4,  1'b1, 8'd3};

    rst         = 1'b1;
    bus.gray_in = 4'b0000;
    #12;
    check("reset_bin_out",   32'(bus.bin_out),   0);
    check("reset_bin_valid", 32'(bus.bin_valid), 0);
    check("reset_delta",     32'(bus.delta),     0);
    check("reset_step_err",  32'(bus.step_err),  0);
    check("reset_err_cnt",   32'(bus.err_cnt),   0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // No event should be generated for the presumed post-reset code 0.
    any_valid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.bin_valid === 1'b1) any_valid = 1'b1;
    end
    check("idle_no_valid", 32'(any_valid), 0);

    for (int i = 0; i < 7; i++) begin
      apply_code(vecs[i].gray, edges, seen);
      check($sformatf("v%0d_latency", i), seen ? edges : 999, 5);
      check($sformatf("v%0d_bin_out", i),  32'(bus.bin_out),  32'(vecs[i].bin));
      check($sformatf("v%0d_delta", i),    32'(bus.delta),    32'(vecs[i].delta));
      check($sformatf("v%0d_step_err", i), 32'(bus.step_err), 32'(vecs[i].se));
      check($sformatf("v%0d_err_cnt", i),  32'(bus.err_cnt),  32'(vecs[i].ec));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid_drop", i), 32'(bus.bin_valid), 0);
      check($sformatf("v%0d_delta_hold", i), 32'(bus.delta),     32'(vecs[i].delta));
    end

    // Glitch: 0011 visible in the sample for only two cycles, then back to 0000.
    do_reset();
    bus.gray_in = 4'b0011;
    repeat (2) @(posedge clk);
    #1;
    bus.gray_in = 4'b0000;
    any_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.bin_valid === 1'b1) any_valid = 1'b1;
    end
    check("glitch_no_valid", 32'(any_valid),   0);
    check("glitch_bin_out",  32'(bus.bin_out), 0);
    apply_code(4'b0001, edges, seen);
    check("post_glitch_latency", seen ? edges : 999, 5);
    check("post_glitch_bin_out", 32'(bus.bin_out), 1);
    check("post_glitch_delta",   32'(bus.delta),   1);

    // Reset asserted one edge after the FSM has entered SETTLE.
    do_reset();
    bus.gray_in = 4'b0110;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_bin_out",  32'(bus.bin_out),  0);
    check("midrst_delta",    32'(bus.delta),    0);
    check("midrst_step_err", 32'(bus.step_err), 0);
    check("midrst_err_cnt",  32'(bus.err_cnt),  0);
    any_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.bin_valid === 1'b1) any_valid = 1'b1;
    end
    check("midrst_no_valid", 32'(any_valid), 0);
    rst = 1'b0;
    wait_valid(edges, seen);
    check("midrst_latency",  seen ? edges : 999, 5);
    check("midrst_bin_after",  32'(bus.bin_out),  4);
    check("midrst_delta_after", 32'(bus.delta),   4);
    check("midrst_se_after",   32'(bus.step_err), 1);
    check("midrst_ec_after",   32'(bus.err_cnt),  1);

    // Saturation: 300 two-bit jumps between 0000 and 0101.
    do_reset();
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < 300; i++) begin
      apply_code((i % 2 == 0) ? 4'b0101 : 4'b0000, edges, seen);
      exp_ec = (i + 1 > 255) ? 255 : i + 1;
      if (seen) pulses++;
      if (!seen || bus.step_err !== 1'b1 || int'(bus.err_cnt) != exp_ec) bad++;
      if (i == 299) begin
        check("sat_bin_out_last", 32'(bus.bin_out), 0);
        check("sat_delta_last",   32'(bus.delta),   10);
      end
    end
    check("sat_pulses",   pulses, 300);
    check("sat_per_step", bad,    0);
    check("sat_err_cnt",  32'(bus.err_cnt),  255);
    check("sat_step_err", 32'(bus.step_err), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
